// File: rtl/sodor_verif_pkg.sv
// Shared constants and enums for the Sodor lockstep verification harness.
// Holds the NOP word, opcodes, instruction-shaping modes and checker FSM states.
package sodor_verif_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0]  OPC_ITYPE = 7'h13;
   localparam logic [6:0]  OPC_RTYPE = 7'h33;

   typedef enum logic [1:0] {
      MODE_PASSTHRU = 2'd0,
      MODE_ITYPE    = 2'd1,
      MODE_RTYPE    = 2'd2,
      MODE_MIXED    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_WARMUP     = 2'd1,
      ST_CHECK      = 2'd2,
      ST_FAIL       = 2'd3
   } state_e;

endpackage

// File: rtl/sodor_instr_shaper.sv
// Combinational shaper: turns a free 32-bit word into a legal ALU instruction
// according to the selected mode, with zero latency.
module sodor_instr_shaper
   import sodor_verif_pkg::*;
(
   input  logic [31:0] raw_instr,
   input  logic [1:0]  mode,
   output logic [31:0] shaped_instr
);

   logic [11:0] imm;
   logic [11:0] imm_legal;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [2:0]  f3;
   logic [6:0]  f7_legal;
   logic [31:0] itype_word;
   logic [31:0] rtype_word;

   assign imm = raw_instr[31:20];
   assign rs2 = raw_instr[24:20];
   assign rs1 = raw_instr[19:15];
   assign f3  = raw_instr[14:12];
   assign rd  = raw_instr[11:7];

   // Shift-immediates must keep only the shamt bits (plus bit 10 for SRAI).
   always_comb begin
      imm_legal = imm;
      if (f3 == 3'd1) begin
         imm_legal = imm & 12'h01F;
      end else if (f3 == 3'd5) begin
         imm_legal = imm & 12'h41F;
      end
   end

   // Only ADD/SUB and SRL/SRA have a legal non-zero funct7 (bit 30).
   always_comb begin
      f7_legal = 7'd0;
      if ((f3 == 3'd0) || (f3 == 3'd5)) begin
         f7_legal = {1'b0, raw_instr[30], 5'b0};
      end
   end

   assign itype_word = {imm_legal, rs1, f3, rd, OPC_ITYPE};
   assign rtype_word = {f7_legal, rs2, rs1, f3, rd, OPC_RTYPE};

   always_comb begin
      shaped_instr = raw_instr;
      case (mode_e'(mode))
         MODE_PASSTHRU: shaped_instr = raw_instr;
         MODE_ITYPE:    shaped_instr = itype_word;
         MODE_RTYPE:    shaped_instr = rtype_word;
         MODE_MIXED:    shaped_instr = raw_instr[0] ? rtype_word : itype_word;
         default:       shaped_instr = raw_instr;
      endcase
   end

endmodule

// File: rtl/sodor_lockstep_checker.sv
// Lockstep harness: sequences core reset and warm-up, feeds a shaped/held
// instruction stream, and compares design vs model channels with sticky failure capture.
module sodor_lockstep_checker
   import sodor_verif_pkg::*;
#(
   parameter int NCH           = 17,
   parameter int CH_W          = 32,
   parameter int RESET_CYCLES  = 2,
   parameter int WARMUP_CYCLES = 4,
   parameter int CYC_W         = 16,
   parameter int CNT_W         = 8,
   parameter int STOP_ON_FAIL  = 1,
   localparam int CHAN_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           raw_instr,
   input  logic [1:0]            mode,
   input  logic                  imem_req_valid,
   input  logic [NCH-1:0]        chan_mask,
   input  logic [NCH*CH_W-1:0]   de_ports,
   input  logic [NCH*CH_W-1:0]   mo_ports,
   output logic                  core_reset,
   output logic [31:0]           instr_out,
   output logic                  check_active,
   output logic                  fail,
   output logic [CHAN_W-1:0]     first_fail_chan,
   output logic [CYC_W-1:0]      first_fail_cycle,
   output logic [CNT_W-1:0]      mismatch_cnt
);

   localparam int RST_LEN = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
   localparam int WRM_LEN = (WARMUP_CYCLES < 1) ? 1 : WARMUP_CYCLES;
   localparam int PH_MAX  = (RST_LEN > WRM_LEN) ? RST_LEN : WRM_LEN;
   localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_LEN - 1);
   localparam logic [PH_W-1:0] WRM_LAST = PH_W'(WRM_LEN - 1);

   state_e              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [CYC_W-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]    mismatch_cnt_q, mismatch_cnt_d;
   logic                fail_q, fail_d;
   logic [CHAN_W-1:0]   first_fail_chan_q, first_fail_chan_d;
   logic [CYC_W-1:0]    first_fail_cycle_q, first_fail_cycle_d;
   logic [31:0]         held_q, held_d;

   logic [31:0]         shaped_instr;
   logic [NCH-1:0]      mismatch_vec;
   logic                any_mm;
   logic [CHAN_W-1:0]   lowest_mm;

   sodor_instr_shaper u_shaper (
      .raw_instr    (raw_instr),
      .mode         (mode),
      .shaped_instr (shaped_instr)
   );

   always_comb begin
      mismatch_vec = '0;
      for (int i = 0; i < NCH; i++) begin
         mismatch_vec[i] = chan_mask[i] &
                           (de_ports[i*CH_W +: CH_W] != mo_ports[i*CH_W +: CH_W]);
      end
   end

   assign any_mm = |mismatch_vec;

   // Scan from the top down so the lowest mismatching index is the one left standing.
   always_comb begin
      lowest_mm = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mismatch_vec[i]) begin
            lowest_mm = CHAN_W'(i);
         end
      end
   end

   assign core_reset   = (state_q == ST_RESET_HOLD);
   assign check_active = (state_q == ST_CHECK);
   assign instr_out    = core_reset     ? NOP_INSTR :
                         imem_req_valid ? shaped_instr : held_q;

   always_comb begin
      state_d            = state_q;
      phase_d            = phase_q;
      cycle_cnt_d        = cycle_cnt_q;
      mismatch_cnt_d     = mismatch_cnt_q;
      fail_d             = fail_q;
      first_fail_chan_d  = first_fail_chan_q;
      first_fail_cycle_d = first_fail_cycle_q;
      held_d             = instr_out;

      if ((state_q != ST_RESET_HOLD) && (state_q != ST_FAIL) && (cycle_cnt_q != '1)) begin
         cycle_cnt_d = cycle_cnt_q + 1'b1;
      end

      case (state_q)
         ST_RESET_HOLD: begin
            phase_d = phase_q + 1'b1;
            if (phase_q == RST_LAST) begin
               phase_d = '0;
               state_d = (WARMUP_CYCLES < 1) ? ST_CHECK : ST_WARMUP;
            end
         end
         ST_WARMUP: begin
            phase_d = phase_q + 1'b1;
            if (phase_q == WRM_LAST) begin
               phase_d = '0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (any_mm) begin
               if (mismatch_cnt_q != '1) begin
                  mismatch_cnt_d = mismatch_cnt_q + 1'b1;
               end
               if (!fail_q) begin
                  fail_d             = 1'b1;
                  first_fail_chan_d  = lowest_mm;
                  first_fail_cycle_d = cycle_cnt_q;
               end
               if (STOP_ON_FAIL != 0) begin
                  state_d = ST_FAIL;
               end
            end
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_RESET_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_RESET_HOLD;
         phase_q            <= '0;
         cycle_cnt_q        <= '0;
         mismatch_cnt_q     <= '0;
         fail_q             <= 1'b0;
         first_fail_chan_q  <= '0;
         first_fail_cycle_q <= '0;
         held_q             <= NOP_INSTR;
      end else begin
         state_q            <= state_d;
         phase_q            <= phase_d;
         cycle_cnt_q        <= cycle_cnt_d;
         mismatch_cnt_q     <= mismatch_cnt_d;
         fail_q             <= fail_d;
         first_fail_chan_q  <= first_fail_chan_d;
         first_fail_cycle_q <= first_fail_cycle_d;
         held_q             <= held_d;
      end
   end

   assign fail             = fail_q;
   assign first_fail_chan  = first_fail_chan_q;
   assign first_fail_cycle = first_fail_cycle_q;
   assign mismatch_cnt     = mismatch_cnt_q;

endmodule

// File: tb/tb_sodor_lockstep_checker.sv
// Scoreboard bench for sodor_lockstep_checker: directed stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares against two DUT instances.
module tb_sodor_lockstep_checker;

   localparam int NCH    = 17;
   localparam int CH_W   = 32;
   localparam int CHAN_W = 5;
   localparam int CYC_W  = 16;
   localparam int CNT_W  = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [NCH-1:0] ALL = '1;

   typedef enum int {K_CORE_RESET, K_CHECK_ACTIVE, K_INSTR, K_FAIL,
                     K_FF_CHAN, K_FF_CYCLE, K_MM_CNT} kind_e;

   typedef struct {
      int          inst;
      kind_e       kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] raw_instr;
   logic [1:0] mode;
   logic imem_req_valid;
   logic [NCH-1:0] chan_mask;
   logic [NCH*CH_W-1:0] de_ports;
   logic [NCH*CH_W-1:0] mo_ports;

   logic core_reset_a, check_active_a, fail_a;
   logic [31:0] instr_out_a;
   logic [CHAN_W-1:0] ffc_a;
   logic [CYC_W-1:0] ffcy_a;
   logic [CNT_W-1:0] mm_a;

   logic core_reset_b, check_active_b, fail_b;
   logic [31:0] instr_out_b;
   logic [CHAN_W-1:0] ffc_b;
   logic [CYC_W-1:0] ffcy_b;
   logic [CNT_W-1:0] mm_b;

   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sodor_lockstep_checker #(.STOP_ON_FAIL(1)) dut (
      .clk(clk), .reset(reset), .raw_instr(raw_instr), .mode(mode),
      .imem_req_valid(imem_req_valid), .chan_mask(chan_mask),
      .de_ports(de_ports), .mo_ports(mo_ports),
      .core_reset(core_reset_a), .instr_out(instr_out_a), .check_active(check_active_a),
      .fail(fail_a), .first_fail_chan(ffc_a), .first_fail_cycle(ffcy_a),
      .mismatch_cnt(mm_a)
   );

   sodor_lockstep_checker #(.STOP_ON_FAIL(0)) dut_nf (
      .clk(clk), .reset(reset), .raw_instr(raw_instr), .mode(mode),
      .imem_req_valid(imem_req_valid), .chan_mask(chan_mask),
      .de_ports(de_ports), .mo_ports(mo_ports),
      .core_reset(core_reset_b), .instr_out(instr_out_b), .check_active(check_active_b),
      .fail(fail_b), .first_fail_chan(ffc_b), .first_fail_cycle(ffcy_b),
      .mismatch_cnt(mm_b)
   );

   function automatic logic [NCH*CH_W-1:0] slot_vec(input logic [NCH-1:0] slots);
      logic [NCH*CH_W-1:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) begin
         if (slots[i]) v[i*CH_W +: CH_W] = 32'hDEAD_BEEF ^ i;
      end
      return v;
   endfunction

   function automatic logic [31:0] actual(input int inst, input kind_e k);
      logic [31:0] r;
      r = '0;
      case (k)
         K_CORE_RESET:   r = {31'd0, inst == 0 ? core_reset_a : core_reset_b};
         K_CHECK_ACTIVE: r = {31'd0, inst == 0 ? check_active_a : check_active_b};
         K_INSTR:        r = inst == 0 ? instr_out_a : instr_out_b;
         K_FAIL:         r = {31'd0, inst == 0 ? fail_a : fail_b};
         K_FF_CHAN:      r = {27'd0, inst == 0 ? ffc_a : ffc_b};
         K_FF_CYCLE:     r = {16'd0, inst == 0 ? ffcy_a : ffcy_b};
         K_MM_CNT:       r = {24'd0, inst == 0 ? mm_a : mm_b};
         default:        r = '0;
      endcase
      return r;
   endfunction

   // Drive one cycle's inputs just after the clock edge.
   task automatic applyStimulus(input logic rst, input logic [1:0] md, input logic [31:0] raw,
                                input logic vld, input logic [NCH-1:0] mask,
                                input logic [NCH-1:0] mm_slots);
      @(posedge clk);
      #1;
      reset          = rst;
      mode           = md;
      raw_instr      = raw;
      imem_req_valid = vld;
      chan_mask      = mask;
      de_ports       = slot_vec(mm_slots);
      mo_ports       = '0;
      cyc++;
   endtask

   task automatic checkOutput(input int inst, input kind_e k, input logic [31:0] e,
                              input string name);
      exp_t x;
      x.inst = inst;
      x.kind = k;
      x.exp  = e;
      x.name = name;
      sb_q.push_back(x);
   endtask

   task automatic expectResetState(input int inst);
      checkOutput(inst, K_CORE_RESET, 1, "rst_core_reset");
      checkOutput(inst, K_CHECK_ACTIVE, 0, "rst_check_active");
      checkOutput(inst, K_INSTR, NOP, "rst_instr_nop");
      checkOutput(inst, K_FAIL, 0, "rst_fail");
      checkOutput(inst, K_FF_CHAN, 0, "rst_ff_chan");
      checkOutput(inst, K_FF_CYCLE, 0, "rst_ff_cycle");
      checkOutput(inst, K_MM_CNT, 0, "rst_mm_cnt");
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t x;
         logic [31:0] a;
         x = sb_q.pop_front();
         a = actual(x.inst, x.kind);
         checks++;
         if (a !== x.exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d cycle %0d: got %h expected %h",
                     x.name, x.inst, cyc, a, x.exp);
         end
      end
   end

   initial begin
      reset = 1'b1; mode = 2'd0; raw_instr = '0; imem_req_valid = 1'b0;
      chan_mask = '0; de_ports = '0; mo_ports = '0;

      applyStimulus(0, 2'd1, 32'hFFFF_D0FF, 1, ALL, '0);                   // c1
      expectResetState(0);
      expectResetState(1);
      applyStimulus(0, 2'd1, 32'hFFFF_D0FF, 1, ALL, '0);                   // c2
      checkOutput(0, K_CORE_RESET, 1, "hold_core_reset");
      applyStimulus(0, 2'd1, 32'hFFFF_D0FF, 1, ALL, '0);                   // c3
      checkOutput(0, K_CORE_RESET, 0, "release_core_reset");
      checkOutput(0, K_INSTR, 32'h41FF_D093, "itype_srai");
      applyStimulus(0, 2'd1, 32'hFFFF_90FF, 1, ALL, 17'h00004);            // c4 warmup mismatch
      checkOutput(0, K_INSTR, 32'h01FF_9093, "itype_slli");
      applyStimulus(0, 2'd2, 32'hFFFF_D0FF, 1, ALL, '0);                   // c5
      checkOutput(0, K_INSTR, 32'h41FF_D0B3, "rtype_sra");
      checkOutput(0, K_FAIL, 0, "warmup_ignored_fail");
      checkOutput(0, K_MM_CNT, 0, "warmup_ignored_cnt");
      applyStimulus(0, 2'd2, 32'hFFFF_FFFF, 1, ALL, '0);                   // c6
      checkOutput(0, K_INSTR, 32'h01FF_FFB3, "rtype_and_f7_zero");
      checkOutput(0, K_CHECK_ACTIVE, 0, "warmup_not_active");
      applyStimulus(0, 2'd3, 32'hFFFF_D0FE, 1, ALL, '0);                   // c7
      checkOutput(0, K_INSTR, 32'h41FF_D093, "mixed_itype");
      checkOutput(0, K_CHECK_ACTIVE, 1, "check_active_c7");
      applyStimulus(0, 2'd3, 32'hFFFF_D0FF, 1, ~(17'd1 << 5), 17'h00020);  // c8 masked mismatch
      checkOutput(0, K_INSTR, 32'h41FF_D0B3, "mixed_rtype");
      applyStimulus(0, 2'd0, 32'h1234_5678, 0, ALL, '0);                   // c9 stall
      checkOutput(0, K_INSTR, 32'h41FF_D0B3, "stall_hold_1");
      checkOutput(0, K_FAIL, 0, "masked_no_fail");
      checkOutput(0, K_MM_CNT, 0, "masked_no_cnt");
      applyStimulus(0, 2'd0, 32'h0000_0000, 0, ALL, '0);                   // c10
      checkOutput(0, K_INSTR, 32'h41FF_D0B3, "stall_hold_2");
      applyStimulus(0, 2'd0, 32'hAAAA_AAAA, 0, ALL, '0);                   // c11
      checkOutput(0, K_INSTR, 32'h41FF_D0B3, "stall_hold_3");
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c12
      checkOutput(0, K_INSTR, 32'h1234_5678, "passthru");
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, 17'h00088);            // c13 cycle_cnt 10, slots 3,7
      checkOutput(0, K_FAIL, 0, "pre_fail");
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c14
      for (int i = 0; i < 2; i++) begin
         checkOutput(i, K_FAIL, 1, "first_fail_flag");
         checkOutput(i, K_FF_CHAN, 3, "first_fail_chan");
         checkOutput(i, K_FF_CYCLE, 10, "first_fail_cycle");
         checkOutput(i, K_MM_CNT, 1, "mm_cnt_first");
      end
      checkOutput(0, K_CHECK_ACTIVE, 0, "stop_on_fail_inactive");
      checkOutput(1, K_CHECK_ACTIVE, 1, "no_stop_still_active");
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, 17'h00002);            // c15 cycle_cnt 12, slot 1
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c16
      checkOutput(0, K_MM_CNT, 1, "fail_state_frozen_cnt");
      checkOutput(0, K_FF_CHAN, 3, "fail_state_chan_kept");
      checkOutput(1, K_MM_CNT, 2, "mm_cnt_second");
      checkOutput(1, K_FF_CHAN, 3, "no_overwrite_chan");
      checkOutput(1, K_FF_CYCLE, 10, "no_overwrite_cycle");
      for (int n = 0; n < 300; n++) begin                                   // c17..c316
         applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, 17'h00001);
      end
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c317
      checkOutput(1, K_MM_CNT, 255, "mm_cnt_saturate");
      checkOutput(1, K_FF_CHAN, 3, "sat_chan_kept");
      checkOutput(1, K_FF_CYCLE, 10, "sat_cycle_kept");
      checkOutput(0, K_MM_CNT, 1, "stop_cnt_unchanged");
      applyStimulus(1, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c318 mid-run reset
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c319
      expectResetState(0);
      expectResetState(1);
      applyStimulus(0, 2'd0, 32'h1234_5678, 1, ALL, '0);                   // c320
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
